// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Size encodings, FSM states and the default memory depth.
package lsu_pkg;

  localparam int MEM_WORDS_DEF = 1024;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RESP
  } state_t;

endpackage

// File: rtl/lsu_if.sv
// Request, response and memory-port bundle of the load/store unit.
// The LSU side is the slave; the core/memory side is the master.
interface lsu_if #(
  parameter int ADDR_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  mem_we;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, mem_address, mem_wdata,
    output mem_we
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, mem_address, mem_wdata,
    input  mem_we
  );

endinterface

// File: rtl/lsu_lane_align.sv
// Byte/half lane handling: store merge into an old word,
// and load extraction with sign or zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [15:0] wdata,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  output logic [31:0] merged,
  output logic [31:0] loaded
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    merged = word;
    loaded = word;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    unique case (1'b1)
      size == SZ_BYTE: begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        loaded = {{24{~uns & b[7]}}, b};
      end
      size == SZ_HALF: begin
        merged[{lane[1], 4'b0000} +: 16] = wdata;
        loaded = {{16{~uns & h[15]}}, h};
      end
      default: begin
        merged = word;
        loaded = word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store sequencer for a single-port word memory.
// Sub-word stores run read-modify-write over RD then WR.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS  = MEM_WORDS_DEF,
  parameter int ADDR_WIDTH = 32
) (
  input  logic  clk,
  input  logic  resetn,
  lsu_if.slave  bus
);

  localparam logic [ADDR_WIDTH-3:0] WLIM =
    (ADDR_WIDTH-2)'(MEM_WORDS);

  state_t                state;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_uns;
  logic [1:0]            r_lane;
  logic [15:0]           r_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [31:0]           mem_wdata;
  logic                  mem_we;
  logic                  err;
  logic [31:0]           merged;
  logic [31:0]           loaded;

  assign bus.req_ready   = (state == S_IDLE);
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_rdata   = rsp_rdata;
  assign bus.rsp_err     = rsp_err;
  assign bus.mem_address = mem_address;
  assign bus.mem_wdata   = mem_wdata;
  assign bus.mem_we      = mem_we;

  always_comb begin
    err = 1'b0;
    unique case (1'b1)
      bus.req_size == SZ_ILL:  err = 1'b1;
      bus.req_size == SZ_HALF: err = bus.req_addr[0];
      bus.req_size == SZ_WORD: err = |bus.req_addr[1:0];
      default:                 err = 1'b0;
    endcase
    if (bus.req_addr[ADDR_WIDTH-1:2] >= WLIM)
      err = 1'b1;
  end

  lsu_lane_align u_align (
    .word   (bus.mem_rdata),
    .wdata  (r_wdata),
    .size   (r_size),
    .lane   (r_lane),
    .uns    (r_uns),
    .merged (merged),
    .loaded (loaded)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      r_we        <= 1'b0;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
      r_lane      <= 2'b00;
      r_wdata     <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_we      <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            r_we    <= bus.req_we;
            r_size  <= bus.req_size;
            r_uns   <= bus.req_unsigned;
            r_lane  <= bus.req_addr[1:0];
            r_wdata <= bus.req_wdata[15:0];
            if (err) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
              state     <= S_RESP;
            end else begin
              mem_address <= {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};
              // Full-word stores need no old data, skip the read
              if (bus.req_we && bus.req_size == SZ_WORD) begin
                mem_wdata <= bus.req_wdata;
                mem_we    <= 1'b1;
                state     <= S_WR;
              end else begin
                state <= S_RD;
              end
            end
          end
        end
        S_RD: begin
          if (r_we) begin
            mem_wdata <= merged;
            mem_we    <= 1'b1;
            state     <= S_WR;
          end else begin
            rsp_rdata <= loaded;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_WR: begin
          mem_we    <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a word memory model.
// Vector table plus stall and mid-operation reset sequences.
module tb_load_store_unit;

  logic clk;
  logic resetn;
  logic preload;
  int   total;
  int   bad;

  lsu_if #(.ADDR_WIDTH(32)) bus ();

  load_store_unit #(
    .MEM_WORDS  (1024),
    .ADDR_WIDTH (32)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [1024];

  assign bus.mem_rdata = mem[bus.mem_address[11:2]];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= (i == 4) ? 32'h8899AABB : 32'h0;
    end else if (bus.mem_we) begin
      mem[bus.mem_address[11:2]] <= bus.mem_wdata;
    end
  end

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wes;
    int          wec;
    logic [31:0] word;
  } vec_t;

  vec_t vt [21];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_req(input logic we, input logic [1:0] sz,
                         input logic uns, input logic [31:0] addr,
                         input logic [31:0] wd,
                         output logic [31:0] rd, output logic er,
                         output int lat, output int wes,
                         output int wec);
    int n;
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++;
      bad++;
      $display("FAIL req_ready_timeout: got 0 want 1");
    end
    @(posedge clk);
    #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = ~we;
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = ~uns;
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
    lat = 0;
    wes = 0;
    wec = -1;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_we) begin
        wes++;
        wec = lat;
      end
    end while (!bus.rsp_valid && lat < 10);
    if (!bus.rsp_valid) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: got 0 want 1");
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          wes;
    int          wec;
    logic [31:0] held;
    logic [31:0] w4;

    total = 0;
    bad   = 0;
    vt[0]  = '{0, 2'd2, 0, 32'h10,  32'h0,        32'h8899AABB, 0, 2, 0, -1, 32'h0};
    vt[1]  = '{0, 2'd0, 0, 32'h13,  32'h0,        32'hFFFFFF88, 0, 2, 0, -1, 32'h0};
    vt[2]  = '{0, 2'd0, 1, 32'h13,  32'h0,        32'h00000088, 0, 2, 0, -1, 32'h0};
    vt[3]  = '{0, 2'd1, 0, 32'h12,  32'h0,        32'hFFFF8899, 0, 2, 0, -1, 32'h0};
    vt[4]  = '{0, 2'd1, 1, 32'h10,  32'h0,        32'h0000AABB, 0, 2, 0, -1, 32'h0};
    vt[5]  = '{1, 2'd0, 0, 32'h11,  32'h55,       32'h0,        0, 3, 1, 2,  32'h889955BB};
    vt[6]  = '{1, 2'd1, 0, 32'h12,  32'h1234,     32'h0,        0, 3, 1, 2,  32'h123455BB};
    vt[7]  = '{0, 2'd2, 0, 32'h10,  32'h0,        32'h123455BB, 0, 2, 0, -1, 32'h0};
    vt[8]  = '{0, 2'd1, 0, 32'h11,  32'h0,        32'h0,        1, 1, 0, -1, 32'h0};
    vt[9]  = '{0, 2'd2, 0, 32'h12,  32'h0,        32'h0,        1, 1, 0, -1, 32'h0};
    vt[10] = '{0, 2'd3, 0, 32'h10,  32'h0,        32'h0,        1, 1, 0, -1, 32'h0};
    vt[11] = '{0, 2'd2, 0, 32'h1000, 32'h0,       32'h0,        1, 1, 0, -1, 32'h0};
    vt[12] = '{1, 2'd2, 0, 32'h1000, 32'h11111111, 32'h0,       1, 1, 0, -1, 32'h0};
    vt[13] = '{1, 2'd2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 1, 1,  32'hDEADBEEF};
    vt[14] = '{0, 2'd0, 0, 32'h12,  32'h0,        32'hFFFFFFAD, 0, 2, 0, -1, 32'h0};
    vt[15] = '{0, 2'd0, 1, 32'h11,  32'h0,        32'h000000BE, 0, 2, 0, -1, 32'h0};
    vt[16] = '{0, 2'd1, 1, 32'h12,  32'h0,        32'h0000DEAD, 0, 2, 0, -1, 32'h0};
    vt[17] = '{0, 2'd1, 0, 32'h10,  32'h0,        32'hFFFFBEEF, 0, 2, 0, -1, 32'h0};
    vt[18] = '{1, 2'd0, 1, 32'hFFF, 32'hFFFFFFA5, 32'h0,        0, 3, 1, 2,  32'hA5000000};
    vt[19] = '{0, 2'd0, 0, 32'hFFF, 32'h0,        32'hFFFFFFA5, 0, 2, 0, -1, 32'h0};
    vt[20] = '{1, 2'd1, 0, 32'h10,  32'hFFFF8001, 32'h0,        0, 3, 1, 2,  32'hDEAD8001};

    resetn           = 1'b0;
    preload          = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.rsp_ready    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    preload = 1'b0;
    resetn  = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_address", bus.mem_address, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);

    for (int i = 0; i < 21; i++) begin
      run_req(vt[i].we, vt[i].sz, vt[i].uns, vt[i].addr, vt[i].wd,
              rd, er, lat, wes, wec);
      chk($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vt[i].er));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("v%0d_we_pulses", i), 32'(wes), 32'(vt[i].wes));
      chk($sformatf("v%0d_we_cycle", i), 32'(wec), 32'(vt[i].wec));
      if (vt[i].wes > 0)
        chk($sformatf("v%0d_mem_word", i),
            mem[vt[i].addr[11:2]], vt[i].word);
      @(negedge clk);
      chk($sformatf("v%0d_rsp_drop", i), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("v%0d_ready_back", i), 32'(bus.req_ready), 32'd1);
    end

    // Response back-pressure with stray request pulses
    w4 = mem[4];
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_size  = 2'd2;
    bus.req_addr  = 32'h10;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 10);
    chk("hold_latency", 32'(lat), 32'd2);
    held = bus.rsp_rdata;
    chk("hold_rdata", held, w4);
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = k[0];
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd2;
      bus.req_addr  = 32'h10;
      bus.req_wdata = 32'h0BAD0BAD;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("hold%0d_rdata", k), bus.rsp_rdata, held);
      chk($sformatf("hold%0d_ready", k), 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("post_hold%0d_valid", k), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("post_hold%0d_we", k), 32'(bus.mem_we), 32'd0);
    end
    chk("hold_word4", mem[4], w4);

    // Reset asserted during the read phase of a byte store
    w4 = mem[4];
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_size  = 2'd0;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0000003C;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_rd_addr", bus.mem_address, 32'h10);
    resetn = 1'b0;
    #1;
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("abort_mem_address", bus.mem_address, 32'd0);
    chk("abort_mem_wdata", bus.mem_wdata, 32'd0);
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("abort%0d_no_rsp", k), 32'(bus.rsp_valid), 32'd0);
    end
    chk("abort_word4", mem[4], w4);

    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, er, lat, wes, wec);
    chk("recover_rdata", rd, w4);
    chk("recover_latency", 32'(lat), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
